pc_fetch_sequencer: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch over a valid/ready request and response interface to instruction memory.
- Accepts redirects, i.e. the branch/jump target computed by the next-PC datapath.
- Delivers fetched instructions with their PC to decode under a stall handshake.
- Keeps at most one fetch outstanding. Sits between the next-PC logic, instruction memory and decode.

---
 rtl/pc_fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC and sequences one-at-a-time
// instruction fetches to instruction memory, handing results to decode under
// a stall handshake. Redirects from the next-PC datapath override sequencing.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target raises a sticky Fault and parks
//               the sequencer in IDLE until reset.
//   undefined : Fault is always 0 and redirect targets are word-aligned on load.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          INSTR_W  = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               run_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [63:0]        redirect_pc_i,
    output logic               imem_req_valid_o,
    output logic [63:0]        imem_req_addr_o,
    input  logic               imem_req_ready_i,
    input  logic               imem_resp_valid_i,
    input  logic [INSTR_W-1:0] imem_resp_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [63:0]        instr_pc_o,
    output logic               fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        fetch_pc_q, fetch_pc_d;
    logic               discard_q, discard_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [63:0]        instr_pc_q, instr_pc_d;
    logic               fault_q, fault_d;

    logic               run_eff;
    logic               redir_bad;
    logic [63:0]        redir_pc;
    logic               held_stall;
    logic               req_fire;

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned targets are trapped rather than silently corrected.
    assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign redir_pc  = redirect_pc_i;
    assign run_eff   = run_i && !fault_q;
`else
    // Low address bits are dropped so the PC stays word-aligned.
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^redirect_pc_i[1:0];
    assign redir_bad = 1'b0;
    assign redir_pc  = {redirect_pc_i[63:2], 2'b00};
    assign run_eff   = run_i;
`endif

    // An undelivered instruction that decode is still refusing blocks any new
    // request, so the single instruction buffer can never be overwritten.
    assign held_stall       = instr_valid_q && stall_i;
    assign imem_req_valid_o = (state_q == S_REQ) && !held_stall;
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign fault_o       = fault_q;

    // Next-state and datapath updates; redirect is applied last so it wins.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        instr_valid_d = instr_valid_q && stall_i;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;

        case (state_q)
            S_IDLE: begin
                if (run_eff) state_d = S_REQ;
            end
            S_REQ: begin
                if (req_fire) begin
                    fetch_pc_d = pc_q;
                    state_d    = S_WAIT;
                end else if (!run_eff) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    if (discard_q || redirect_i) begin
                        // Stale response for a fetch that a redirect killed.
                        discard_d = 1'b0;
                        state_d   = run_eff ? S_REQ : S_IDLE;
                    end else begin
                        instr_d       = imem_resp_data_i;
                        instr_pc_d    = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 64'd4;
                        if (!run_eff)     state_d = S_IDLE;
                        else if (stall_i) state_d = S_HOLD;
                        else              state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) state_d = run_eff ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_i) begin
            instr_valid_d = 1'b0;
            if (redir_bad) begin
                fault_d   = 1'b1;
                state_d   = S_IDLE;
                discard_d = 1'b0;
            end else begin
                pc_d = redir_pc;
                case (state_q)
                    S_IDLE: state_d = S_IDLE;
                    // Accepted on the redirect cycle: its response is stale.
                    S_REQ:  if (req_fire) discard_d = 1'b1;
                    S_WAIT: if (!imem_resp_valid_i) discard_d = 1'b1;
                    S_HOLD: state_d = run_eff ? S_REQ : S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            fetch_pc_q    <= 64'h0;
            discard_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= 64'h0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            discard_q     <= discard_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a transaction-level model (expected fetch PC,
// outstanding fetches, pending deliveries) checked every cycle, plus directed
// scenarios with literal expectations.
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk, rst, run, stall, redir, req_ready, resp_valid;
    logic [63:0] redir_pc;
    logic [31:0] resp_data;
    logic        req_valid, iv, fault;
    logic [63:0] req_addr, ipc;
    logic [31:0] instr;

    pc_fetch_sequencer #(.RESET_PC(RST_PC), .INSTR_W(32)) dut (
        .clk_i(clk), .reset_i(rst), .run_i(run), .stall_i(stall),
        .redirect_i(redir), .redirect_pc_i(redir_pc),
        .imem_req_valid_o(req_valid), .imem_req_addr_o(req_addr),
        .imem_req_ready_i(req_ready), .imem_resp_valid_i(resp_valid),
        .imem_resp_data_i(resp_data), .instr_valid_o(iv), .instr_o(instr),
        .instr_pc_o(ipc), .fault_o(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; bit killed; } out_t;
    typedef struct { logic [63:0] pc; logic [31:0] data; } dlv_t;
    typedef struct { logic [63:0] addr; int due; } rsp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int iv_cycles = 0;
    bit armed = 0;
    bit exp_fault = 0;
    logic [63:0] exp_pc = RST_PC;
    out_t outq[$];
    dlv_t dq[$];
    rsp_t rq[$];
    logic [63:0] acc_log[$];
    dlv_t dlv_log[$];

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a == 64'h2000) ? 32'hDEADBEEF : (a[31:0] ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: answers each accepted request lat cycles later.
    always @(posedge clk) begin
        #1;
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = memf(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
    end

    // Model and per-cycle compare; all signals are stable at the falling edge
    // and describe what the next rising edge will consume.
    always @(negedge clk) begin
        out_t o;
        if (rst) begin
            outq.delete();
            dq.delete();
            exp_pc    = RST_PC;
            exp_fault = 0;
            armed     = 1;
        end else if (armed) begin
            chk("fault", 64'(fault), 64'(exp_fault));
            chk("instr_valid", 64'(iv), 64'(dq.size() != 0));
            if (iv && dq.size() != 0) begin
                chk("instr_pc", ipc, dq[0].pc);
                chk("instr", 64'(instr), 64'(dq[0].data));
            end
            if (req_valid) begin
                chk("req_addr", req_addr, exp_pc);
                chk("req_outstanding", 64'(outq.size()), 64'd0);
                chk("req_while_held", 64'(iv && stall), 64'd0);
                chk("req_in_fault", 64'(exp_fault), 64'd0);
            end
            if (iv) iv_cycles++;
            if (iv && !stall && dq.size() != 0) begin
                dlv_log.push_back(dq[0]);
                void'(dq.pop_front());
            end
            if (resp_valid && outq.size() != 0) begin
                o = outq.pop_front();
                if (!o.killed && !redir && !exp_fault) begin
                    dq.push_back('{pc: o.addr, data: memf(o.addr)});
                    exp_pc = o.addr + 64'd4;
                end
            end
            if (req_valid && req_ready) begin
                outq.push_back('{addr: req_addr, killed: redir});
                acc_log.push_back(req_addr);
                rq.push_back('{addr: req_addr, due: cyc + lat});
            end
            if (redir) begin
                dq.delete();
                foreach (outq[i]) outq[i].killed = 1;
`ifdef FETCH_ALIGN_CHECK_EN
                if (redir_pc[1:0] != 2'b00) exp_fault = 1;
                else exp_pc = redir_pc;
`else
                exp_pc = {redir_pc[63:2], 2'b00};
`endif
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        run = 0; redir = 0; stall = 0; rst = 1;
        step(2);
        rst = 0;
        acc_log.delete();
        dlv_log.delete();
    endtask

    task automatic drain();
        run = 0; redir = 0; stall = 0;
        step(12);
    endtask

    task automatic redirect_to(input logic [63:0] a);
        redir = 1; redir_pc = a;
        step(1);
        redir = 0;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int k = 0;
        while (acc_log.size() < n && k < 60) begin step(1); k++; end
        checks++;
        if (acc_log.size() < n) begin
            errors++;
            $display("FAIL %s timeout accepted=%0d need=%0d", nm, acc_log.size(), n);
        end
    endtask

    task automatic wait_dlv(input int n, input string nm);
        int k = 0;
        while (dlv_log.size() < n && k < 80) begin step(1); k++; end
        checks++;
        if (dlv_log.size() < n) begin
            errors++;
            $display("FAIL %s timeout delivered=%0d need=%0d", nm, dlv_log.size(), n);
        end
    endtask

    initial begin
        int n0;
        int k;
        rst = 1; run = 0; stall = 0; redir = 0; redir_pc = 64'h0; req_ready = 0;
        resp_valid = 0; resp_data = 32'h0;

        // Reset state
        do_reset();
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_instr_valid", 64'(iv), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", ipc, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_addr", req_addr, 64'h1000);

        // Sequential fetch from reset PC
        lat = 1; req_ready = 1; run = 1;
        wait_dlv(3, "t1_dlv");
        chk("t1_acc0", acc_log[0], 64'h1000);
        chk("t1_acc1", acc_log[1], 64'h1004);
        chk("t1_acc2", acc_log[2], 64'h1008);
        chk("t1_dlv0_pc", dlv_log[0].pc, 64'h1000);
        chk("t1_dlv2_pc", dlv_log[2].pc, 64'h1008);
        chk("t1_dlv0_data", 64'(dlv_log[0].data), 64'h13578BDF);
        drain();

        // Stall hold on a delivered instruction
        do_reset();
        lat = 1; req_ready = 1;
        redirect_to(64'h2000);
        run = 1;
        k = 0;
        while (!iv && k < 30) begin step(1); k++; end
        chk("t2_iv_seen", 64'(iv), 64'd1);
        stall = 1; iv_cycles = 0; n0 = acc_log.size();
        step(3);
        chk("t2_iv_held", 64'(iv), 64'd1);
        chk("t2_instr", 64'(instr), 64'hDEADBEEF);
        chk("t2_instr_pc", ipc, 64'h2000);
        chk("t2_no_req", 64'(acc_log.size()), 64'(n0));
        stall = 0;
        step(2);
        chk("t2_iv_cycles", 64'(iv_cycles), 64'd4);
        wait_acc(n0 + 1, "t2_acc");
        chk("t2_next_addr", acc_log[n0], 64'h2004);
        drain();

        // Redirect while waiting drops the in-flight response
        do_reset();
        lat = 4; req_ready = 1;
        redirect_to(64'h3000);
        run = 1;
        wait_acc(1, "t3_acc");
        redirect_to(64'h4000);
        wait_dlv(1, "t3_dlv");
        chk("t3_acc0", acc_log[0], 64'h3000);
        chk("t3_acc1", acc_log[1], 64'h4000);
        chk("t3_first_pc", dlv_log[0].pc, 64'h4000);
        drain();

        // Redirect on the acceptance cycle
        do_reset();
        lat = 2; req_ready = 0;
        redirect_to(64'h4800);
        run = 1;
        step(1);
        chk("t4_req_pending", 64'(req_valid), 64'd1);
        req_ready = 1; redir = 1; redir_pc = 64'h5000;
        step(1);
        redir = 0;
        wait_dlv(1, "t4_dlv");
        chk("t4_acc0", acc_log[0], 64'h4800);
        chk("t4_acc1", acc_log[1], 64'h5000);
        chk("t4_first_pc", dlv_log[0].pc, 64'h5000);
        drain();

        // PC wrap-around
        do_reset();
        lat = 1; req_ready = 1;
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        run = 1;
        wait_acc(2, "t5_acc");
        chk("t5_acc0", acc_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_wrap", acc_log[1], 64'h0);
        drain();

        // Reset during WAIT ignores the late response
        do_reset();
        lat = 5; req_ready = 1;
        redirect_to(64'h7000);
        run = 1;
        wait_acc(1, "t5r_acc");
        step(1);
        rst = 1; run = 0;
        step(1);
        rst = 0;
        chk("t5r_addr", req_addr, 64'h1000);
        chk("t5r_req_valid", 64'(req_valid), 64'd0);
        iv_cycles = 0;
        step(8);
        chk("t5r_no_iv", 64'(iv_cycles), 64'd0);
        chk("t5r_no_dlv", 64'(dlv_log.size()), 64'd0);
        drain();

        // Misaligned redirect
        do_reset();
        lat = 1; req_ready = 1;
        redirect_to(64'h6002);
        run = 1;
`ifdef FETCH_ALIGN_CHECK_EN
        step(10);
        chk("t6_fault", 64'(fault), 64'd1);
        chk("t6_no_acc", 64'(acc_log.size()), 64'd0);
        chk("t6_req_valid", 64'(req_valid), 64'd0);
`else
        wait_acc(1, "t6_acc");
        chk("t6_aligned", acc_log[0], 64'h6000);
        chk("t6_fault", 64'(fault), 64'd0);
`endif
        drain();

        // Mixed stalls, backpressure, latencies and redirects
        do_reset();
        run = 1;
        for (int i = 0; i < 200; i++) begin
            stall     = (i % 7) < 2;
            req_ready = (i % 5) != 0;
            lat       = 1 + (i % 3);
            redir     = (i % 37) == 20;
            redir_pc  = 64'h8000 + 64'(i) * 64'd16;
            step(1);
        end
        drain();
        chk("stress_progress", 64'(dlv_log.size() > 10), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
